// File: rtl/wm8731_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : wm8731_pkg
//  Description : Shared constants for the WM8731 control-port responder:
//                register addresses, power-on register defaults, default
//                device address and FSM state encoding.
//                Optional feature macro: WM8731_RESP_READBACK_EN adds the
//                read-back states to the state encoding.
//  Revision    : 1.0  initial release
// ============================================================================
package wm8731_pkg;

  localparam logic [6:0] DEV_ADDR_DEFAULT = 7'h1A;
  localparam int         NUM_REGS_DEFAULT = 10;

  // Register addresses
  localparam int R_LLINE  = 0;
  localparam int R_RLINE  = 1;
  localparam int R_LHP    = 2;
  localparam int R_RHP    = 3;
  localparam int R_APATH  = 4;
  localparam int R_DPATH  = 5;
  localparam int R_PWR    = 6;
  localparam int R_IFACE  = 7;
  localparam int R_SRATE  = 8;
  localparam int R_ACTIVE = 9;
  localparam int R_RESET  = 15;

  typedef enum logic [3:0] {
    ST_IDLE   = 4'd0,
    ST_DEVADR = 4'd1,
    ST_ACK0   = 4'd2,
    ST_BYTE1  = 4'd3,
    ST_ACK1   = 4'd4,
    ST_BYTE2  = 4'd5,
    ST_ACK2   = 4'd6,
`ifdef WM8731_RESP_READBACK_EN
    ST_WAITP  = 4'd7,
    ST_RDBYTE = 4'd8,
    ST_RDACK  = 4'd9
`else
    ST_WAITP  = 4'd7
`endif
  } state_t;

  // Power-on register values; unimplemented indices default to zero
  function automatic logic [8:0] reg_default(input int idx);
    case (idx)
      R_LLINE:  reg_default = 9'h097;
      R_RLINE:  reg_default = 9'h097;
      R_LHP:    reg_default = 9'h079;
      R_RHP:    reg_default = 9'h079;
      R_APATH:  reg_default = 9'h00A;
      R_DPATH:  reg_default = 9'h008;
      R_PWR:    reg_default = 9'h09F;
      R_IFACE:  reg_default = 9'h00A;
      default:  reg_default = 9'h000;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/i2c_bus_sampler.sv
`default_nettype none
// ============================================================================
//  Module      : i2c_bus_sampler
//  Description : Synchronises SCL/SDA into the clk domain and produces
//                single-cycle SCL rise/fall and START/STOP strobes.
//  Ports       : clk, rst         - clock, asynchronous active-high reset
//                scl_in, sda_in   - raw bus lines
//                sda_s            - synchronised SDA level
//                scl_rise/fall    - synchronised SCL edge strobes
//                start_det        - SDA fell while SCL high
//                stop_det         - SDA rose while SCL high
//  Revision    : 1.0  initial release
// ============================================================================
module i2c_bus_sampler #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic scl_in,
  input  logic sda_in,
  output logic sda_s,
  output logic scl_rise,
  output logic scl_fall,
  output logic start_det,
  output logic stop_det
);

  logic [SYNC_STAGES-1:0] scl_sync_q, scl_sync_d;
  logic [SYNC_STAGES-1:0] sda_sync_q, sda_sync_d;
  logic                   scl_prev_q, sda_prev_q;
  logic                   scl_s;

  always_comb begin
    scl_sync_d = {scl_sync_q[SYNC_STAGES-2:0], scl_in};
    sda_sync_d = {sda_sync_q[SYNC_STAGES-2:0], sda_in};
  end

  // Reset to the idle-bus level so leaving reset never fakes an edge
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scl_sync_q <= '1;
      sda_sync_q <= '1;
      scl_prev_q <= 1'b1;
      sda_prev_q <= 1'b1;
    end else begin
      scl_sync_q <= scl_sync_d;
      sda_sync_q <= sda_sync_d;
      scl_prev_q <= scl_s;
      sda_prev_q <= sda_s;
    end
  end

  assign scl_s     = scl_sync_q[SYNC_STAGES-1];
  assign sda_s     = sda_sync_q[SYNC_STAGES-1];
  assign scl_rise  =  scl_s & ~scl_prev_q;
  assign scl_fall  = ~scl_s &  scl_prev_q;
  assign start_det =  scl_s & scl_prev_q &  sda_prev_q & ~sda_s;
  assign stop_det  =  scl_s & scl_prev_q & ~sda_prev_q &  sda_s;

endmodule
`default_nettype wire

// File: rtl/wm8731_i2c_responder.sv
`default_nettype none
// ============================================================================
//  Module      : wm8731_i2c_responder
//  Description : I2C slave modelling the WM8731 2-wire control port. Decodes
//                3-byte writes {dev+W, addr[6:0]+d[8], d[7:0]}, ACKs each
//                byte and updates a shadow register file.
//                Optional macro WM8731_RESP_READBACK_EN: accept dev+R and
//                return {last_addr, reg[8]}, reg[7:0] of the last written
//                address.
//  Ports       : MCLK, RESET   - clock, asynchronous active-high reset
//                SCL_IN/SDA_IN - bus inputs; SDA_OE pulls SDA low
//                WR_STB/ADDR/DATA - committed write
//                REGS_FLAT     - R0..R(NUM_REGS-1), R0 in [8:0]
//                ACTIVE        - R9[0];  ADDR_ERR - write to bad address
//                BUSY          - between START and STOP
//  Revision    : 1.0  initial release
// ============================================================================
module wm8731_i2c_responder
  import wm8731_pkg::*;
#(
  parameter logic [6:0] DEV_ADDR    = DEV_ADDR_DEFAULT,
  parameter int         SYNC_STAGES = 2,
  parameter int         NUM_REGS    = NUM_REGS_DEFAULT
) (
  input  logic                  MCLK,
  input  logic                  RESET,
  input  logic                  SCL_IN,
  input  logic                  SDA_IN,
  output logic                  SDA_OE,
  output logic                  WR_STB,
  output logic [6:0]            WR_ADDR,
  output logic [8:0]            WR_DATA,
  output logic [9*NUM_REGS-1:0] REGS_FLAT,
  output logic                  ACTIVE,
  output logic                  ADDR_ERR,
  output logic                  BUSY
);

`ifdef WM8731_RESP_READBACK_EN
  localparam bit READ_OK = 1'b1;
`else
  localparam bit READ_OK = 1'b0;
`endif

  logic sda_s, scl_rise, scl_fall, start_det, stop_det;

  i2c_bus_sampler #(.SYNC_STAGES(SYNC_STAGES)) u_sampler (
    .clk       (MCLK),
    .rst       (RESET),
    .scl_in    (SCL_IN),
    .sda_in    (SDA_IN),
    .sda_s     (sda_s),
    .scl_rise  (scl_rise),
    .scl_fall  (scl_fall),
    .start_det (start_det),
    .stop_det  (stop_det)
  );

  state_t                     state_q, state_d;
  logic [2:0]                 cnt_q, cnt_d;
  logic [7:0]                 sr_q, sr_d;
  logic [7:0]                 b1_q, b1_d;
  logic                       phase_q, phase_d;   // 0: ACK not yet driven
  logic                       sda_oe_q, sda_oe_d;
  logic                       wr_stb_q, wr_stb_d;
  logic [6:0]                 wr_addr_q, wr_addr_d;
  logic [8:0]                 wr_data_q, wr_data_d;
  logic                       addr_err_q, addr_err_d;
  logic                       busy_q, busy_d;
  logic [NUM_REGS-1:0][8:0]   regs_q, regs_d;

  logic       commit, dev_ok;
  logic [6:0] cm_addr;
  logic [8:0] cm_data;

  assign cm_addr = b1_q[7:1];
  assign cm_data = {b1_q[0], sr_q};
  assign dev_ok  = (sr_q[7:1] == DEV_ADDR) && (READ_OK || !sr_q[0]);

`ifdef WM8731_RESP_READBACK_EN
  logic [6:0] last_addr_q, last_addr_d;
  logic       rd_sel_q, rd_sel_d;   // which byte the next read returns
  logic       mack_q, mack_d;       // master acknowledged last read byte
  logic [8:0] rd_val;
  logic [7:0] rd_byte0, rd_next;

  always_comb begin
    rd_val = 9'h000;
    for (int i = 0; i < NUM_REGS; i++)
      if (last_addr_q == 7'(i)) rd_val = regs_q[i];
  end
  assign rd_byte0 = {last_addr_q, rd_val[8]};
  assign rd_next  = rd_sel_q ? rd_val[7:0] : rd_byte0;
`endif

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    sr_d       = sr_q;
    b1_d       = b1_q;
    phase_d    = phase_q;
    sda_oe_d   = sda_oe_q;
    wr_stb_d   = 1'b0;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;
    addr_err_d = 1'b0;
    busy_d     = busy_q;
    regs_d     = regs_q;
    commit     = 1'b0;
`ifdef WM8731_RESP_READBACK_EN
    last_addr_d = last_addr_q;
    rd_sel_d    = rd_sel_q;
    mack_d      = mack_q;
`endif

    if (stop_det) begin
      state_d  = ST_IDLE;
      sda_oe_d = 1'b0;
      busy_d   = 1'b0;
    end else if (start_det) begin
      state_d  = ST_DEVADR;
      cnt_d    = 3'd0;
      phase_d  = 1'b0;
      sda_oe_d = 1'b0;
      busy_d   = 1'b1;
    end else begin
      case (state_q)
        ST_DEVADR, ST_BYTE1, ST_BYTE2: begin
          if (scl_rise) begin
            sr_d  = {sr_q[6:0], sda_s};
            cnt_d = cnt_q + 3'd1;
            if (cnt_q == 3'd7) begin
              phase_d = 1'b0;
              case (state_q)
                ST_DEVADR: state_d = ST_ACK0;
                ST_BYTE1:  state_d = ST_ACK1;
                default:   state_d = ST_ACK2;
              endcase
            end
          end
        end
        ST_ACK0: begin
          if (scl_fall) begin
            if (!phase_q) begin
              if (dev_ok) begin
                sda_oe_d = 1'b1;
                phase_d  = 1'b1;
              end else begin
                state_d = ST_WAITP;
              end
            end else begin
              sda_oe_d = 1'b0;
              phase_d  = 1'b0;
              cnt_d    = 3'd0;
              state_d  = ST_BYTE1;
`ifdef WM8731_RESP_READBACK_EN
              if (sr_q[0]) begin
                // First read bit goes out on the same fall that ends the ACK
                state_d  = ST_RDBYTE;
                sr_d     = rd_byte0;
                sda_oe_d = ~rd_byte0[7];
                rd_sel_d = 1'b1;
              end
`endif
            end
          end
        end
        ST_ACK1, ST_ACK2: begin
          if (scl_fall) begin
            if (!phase_q) begin
              sda_oe_d = 1'b1;
              phase_d  = 1'b1;
              if (state_q == ST_ACK1) b1_d = sr_q;
            end else begin
              sda_oe_d = 1'b0;
              phase_d  = 1'b0;
              cnt_d    = 3'd0;
              if (state_q == ST_ACK1) begin
                state_d = ST_BYTE2;
              end else begin
                commit  = 1'b1;
                state_d = ST_WAITP;
              end
            end
          end
        end
`ifdef WM8731_RESP_READBACK_EN
        ST_RDBYTE: begin
          if (scl_fall) begin
            sr_d     = {sr_q[6:0], 1'b0};
            sda_oe_d = ~sr_q[6];
          end
          if (scl_rise) begin
            cnt_d = cnt_q + 3'd1;
            if (cnt_q == 3'd7) begin
              phase_d = 1'b0;
              state_d = ST_RDACK;
            end
          end
        end
        ST_RDACK: begin
          if (scl_rise && phase_q) mack_d = ~sda_s;
          if (scl_fall) begin
            if (!phase_q) begin
              sda_oe_d = 1'b0;   // hand SDA to the master for its ACK
              phase_d  = 1'b1;
            end else begin
              phase_d = 1'b0;
              cnt_d   = 3'd0;
              if (mack_q) begin
                state_d  = ST_RDBYTE;
                sr_d     = rd_next;
                sda_oe_d = ~rd_next[7];
                rd_sel_d = ~rd_sel_q;
              end else begin
                state_d = ST_WAITP;
              end
            end
          end
        end
`endif
        default: ;
      endcase
    end

    if (commit) begin
`ifdef WM8731_RESP_READBACK_EN
      last_addr_d = cm_addr;
`endif
      if (cm_addr < 7'(NUM_REGS)) begin
        wr_stb_d  = 1'b1;
        wr_addr_d = cm_addr;
        wr_data_d = cm_data;
        for (int i = 0; i < NUM_REGS; i++)
          if (cm_addr == 7'(i)) regs_d[i] = cm_data;
      end else if (cm_addr == 7'(R_RESET)) begin
        wr_stb_d  = 1'b1;
        wr_addr_d = cm_addr;
        wr_data_d = cm_data;
        if (cm_data == 9'h000)
          for (int i = 0; i < NUM_REGS; i++) regs_d[i] = reg_default(i);
      end else begin
        addr_err_d = 1'b1;
      end
    end
  end

  always_ff @(posedge MCLK or posedge RESET) begin
    if (RESET) begin
      state_q    <= ST_IDLE;
      cnt_q      <= 3'd0;
      sr_q       <= 8'h00;
      b1_q       <= 8'h00;
      phase_q    <= 1'b0;
      sda_oe_q   <= 1'b0;
      wr_stb_q   <= 1'b0;
      wr_addr_q  <= 7'h00;
      wr_data_q  <= 9'h000;
      addr_err_q <= 1'b0;
      busy_q     <= 1'b0;
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= reg_default(i);
`ifdef WM8731_RESP_READBACK_EN
      last_addr_q <= 7'h00;
      rd_sel_q    <= 1'b0;
      mack_q      <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      sr_q       <= sr_d;
      b1_q       <= b1_d;
      phase_q    <= phase_d;
      sda_oe_q   <= sda_oe_d;
      wr_stb_q   <= wr_stb_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
      addr_err_q <= addr_err_d;
      busy_q     <= busy_d;
      regs_q     <= regs_d;
`ifdef WM8731_RESP_READBACK_EN
      last_addr_q <= last_addr_d;
      rd_sel_q    <= rd_sel_d;
      mack_q      <= mack_d;
`endif
    end
  end

  assign SDA_OE    = sda_oe_q;
  assign WR_STB    = wr_stb_q;
  assign WR_ADDR   = wr_addr_q;
  assign WR_DATA   = wr_data_q;
  assign REGS_FLAT = regs_q;
  assign ACTIVE    = regs_q[R_ACTIVE][0];
  assign ADDR_ERR  = addr_err_q;
  assign BUSY      = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_wm8731_i2c_responder.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : tb_wm8731_i2c_responder
//  Description : Self-checking bench for wm8731_i2c_responder. An I2C master
//                model drives the bus; a register-file model predicts ACKs,
//                write strobes, address errors and the shadow registers.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_wm8731_i2c_responder;

  localparam int Q = 100;   // quarter SCL period in ns (SCL = 20 MCLK)

  logic        MCLK = 1'b0;
  logic        RESET = 1'b1;
  logic        scl_m = 1'b1;
  logic        sda_m = 1'b1;
  logic        sda_line;
  logic        SDA_OE, WR_STB, ACTIVE, ADDR_ERR, BUSY;
  logic [6:0]  WR_ADDR;
  logic [8:0]  WR_DATA;
  logic [89:0] REGS_FLAT;

  assign sda_line = sda_m & ~SDA_OE;

  wm8731_i2c_responder #(.DEV_ADDR(7'h1A), .SYNC_STAGES(2), .NUM_REGS(10)) dut (
    .MCLK(MCLK), .RESET(RESET), .SCL_IN(scl_m), .SDA_IN(sda_line),
    .SDA_OE(SDA_OE), .WR_STB(WR_STB), .WR_ADDR(WR_ADDR), .WR_DATA(WR_DATA),
    .REGS_FLAT(REGS_FLAT), .ACTIVE(ACTIVE), .ADDR_ERR(ADDR_ERR), .BUSY(BUSY)
  );

  always #10 MCLK = ~MCLK;

  int total = 0;
  int bad   = 0;

  // ---------------- bus monitor ----------------
  int         stb_cnt = 0, err_cnt = 0, oe_viol = 0;
  logic [6:0] mon_addr = 7'h00;
  logic [8:0] mon_data = 9'h000;
  logic       oe_seen = 1'b0, oe_prev = 1'b0, mon_en = 1'b1;
  logic [4:0] scl_hist = 5'h1F;

  always @(negedge MCLK) begin
    if (WR_STB) begin
      stb_cnt  = stb_cnt + 1;
      mon_addr = WR_ADDR;
      mon_data = WR_DATA;
    end
    if (ADDR_ERR) err_cnt = err_cnt + 1;
    if (SDA_OE) oe_seen = 1'b1;
    scl_hist = {scl_hist[3:0], scl_m};
    if (mon_en && (SDA_OE !== oe_prev) && (&scl_hist)) oe_viol = oe_viol + 1;
    oe_prev = SDA_OE;
  end

  // ---------------- reference model ----------------
  logic [8:0] m_regs [10];
  logic [6:0] m_last_addr = 7'h00;

  function automatic logic [8:0] dflt(input int i);
    logic [8:0] t [10] = '{9'h097, 9'h097, 9'h079, 9'h079, 9'h00A,
                           9'h008, 9'h09F, 9'h00A, 9'h000, 9'h000};
    return t[i];
  endfunction

  task automatic m_reset();
    for (int i = 0; i < 10; i++) m_regs[i] = dflt(i);
    m_last_addr = 7'h00;
  endtask

  function automatic logic [89:0] m_flat();
    logic [89:0] f;
    for (int i = 0; i < 10; i++) f[i*9 +: 9] = m_regs[i];
    return f;
  endfunction

  // Applies a completed write; returns whether WR_STB / ADDR_ERR should pulse
  task automatic m_write(input logic [6:0] a, input logic [8:0] d,
                         output logic stb, output logic err);
    stb = 1'b0; err = 1'b0;
    m_last_addr = a;
    if (a <= 7'd9) begin
      stb = 1'b1; m_regs[int'(a)] = d;
    end else if (a == 7'h0F) begin
      stb = 1'b1;
      if (d == 9'h000) for (int i = 0; i < 10; i++) m_regs[i] = dflt(i);
    end else begin
      err = 1'b1;
    end
  endtask

  // ---------------- bus master ----------------
  task automatic i2c_start();
    sda_m = 1'b1; #Q; scl_m = 1'b1; #Q; sda_m = 1'b0; #Q; scl_m = 1'b0; #Q;
  endtask

  task automatic i2c_stop();
    sda_m = 1'b0; #Q; scl_m = 1'b1; #Q; sda_m = 1'b1; #(2*Q);
  endtask

  task automatic send_byte(input logic [7:0] b, output logic ack);
    for (int i = 7; i >= 0; i--) begin
      sda_m = b[i]; #Q; scl_m = 1'b1; #(2*Q); scl_m = 1'b0; #Q;
    end
    sda_m = 1'b1; #Q; scl_m = 1'b1; #Q;
    ack = (sda_line === 1'b0);
    #Q; scl_m = 1'b0; #Q;
  endtask

  task automatic recv_byte(input logic mack, output logic [7:0] b);
    for (int i = 7; i >= 0; i--) begin
      sda_m = 1'b1; #Q; scl_m = 1'b1; #Q; b[i] = sda_line; #Q; scl_m = 1'b0; #Q;
    end
    sda_m = ~mack; #Q; scl_m = 1'b1; #(2*Q); scl_m = 1'b0; #Q; sda_m = 1'b1;
  endtask

  task automatic do_write(input logic [7:0] dv, input logic [7:0] b1,
                          input logic [7:0] b2, output logic [2:0] acks);
    logic a0, a1, a2;
    i2c_start();
    send_byte(dv, a0); send_byte(b1, a1); send_byte(b2, a2);
    i2c_stop();
    acks = {a0, a1, a2};
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    RESET = 1'b1;
    repeat (5) @(posedge MCLK);
    #1 RESET = 1'b0;
    repeat (3) @(posedge MCLK);
    #1;
    m_reset();
    total++; if (SDA_OE !== 1'b0) begin bad++; $display("FAIL reset_sda_oe got=%b exp=0", SDA_OE); end
    total++; if (WR_STB !== 1'b0 || ADDR_ERR !== 1'b0 || BUSY !== 1'b0) begin bad++;
      $display("FAIL reset_strobes got stb=%b err=%b busy=%b exp 0", WR_STB, ADDR_ERR, BUSY); end
    total++; if (WR_ADDR !== 7'h00 || WR_DATA !== 9'h000) begin bad++;
      $display("FAIL reset_wr got addr=%h data=%h exp 0", WR_ADDR, WR_DATA); end
    total++; if (REGS_FLAT !== m_flat()) begin bad++;
      $display("FAIL reset_regs got=%h exp=%h", REGS_FLAT, m_flat()); end
    total++; if (ACTIVE !== 1'b0) begin bad++; $display("FAIL reset_active got=%b exp=0", ACTIVE); end
  endtask

  task automatic test_write_r7();
    logic [2:0] acks; int s0; logic stb, err;
    s0 = stb_cnt;
    do_write(8'h34, 8'h0E, 8'h53, acks);
    m_write(7'h07, 9'h053, stb, err);
    total++; if (acks !== 3'b111) begin bad++; $display("FAIL r7_acks got=%b exp=111", acks); end
    total++; if (stb_cnt - s0 !== 1) begin bad++; $display("FAIL r7_stb_count got=%0d exp=1", stb_cnt - s0); end
    total++; if (mon_addr !== 7'h07 || mon_data !== 9'h053) begin bad++;
      $display("FAIL r7_wr got addr=%h data=%h exp 07/053", mon_addr, mon_data); end
    total++; if (REGS_FLAT[71:63] !== 9'h053) begin bad++;
      $display("FAIL r7_reg got=%h exp=053", REGS_FLAT[71:63]); end
  endtask

  task automatic test_active_and_reset_reg();
    logic [2:0] acks; int s0; logic stb, err;
    do_write(8'h34, 8'h12, 8'h01, acks);
    m_write(7'h09, 9'h001, stb, err);
    total++; if (ACTIVE !== 1'b1) begin bad++; $display("FAIL active_set got=%b exp=1", ACTIVE); end
    s0 = stb_cnt;
    do_write(8'h34, 8'h1E, 8'h00, acks);
    m_write(7'h0F, 9'h000, stb, err);
    total++; if (stb_cnt - s0 !== 1 || mon_addr !== 7'h0F) begin bad++;
      $display("FAIL resetreg_stb got n=%0d addr=%h exp 1/0F", stb_cnt - s0, mon_addr); end
    total++; if (REGS_FLAT !== m_flat() || ACTIVE !== 1'b0) begin bad++;
      $display("FAIL resetreg_regs got=%h act=%b exp=%h act=0", REGS_FLAT, ACTIVE, m_flat()); end
  endtask

  task automatic test_bad_devaddr();
    logic [2:0] acks; int s0;
    s0 = stb_cnt; oe_seen = 1'b0;
    do_write(8'h36, 8'h0E, 8'h53, acks);
    total++; if (acks !== 3'b000) begin bad++; $display("FAIL baddev_acks got=%b exp=000", acks); end
    total++; if (oe_seen !== 1'b0 || stb_cnt != s0) begin bad++;
      $display("FAIL baddev_quiet got oe_seen=%b stb=%0d exp 0/0", oe_seen, stb_cnt - s0); end
  endtask

  task automatic test_addr_err();
    logic [2:0] acks; int s0, e0;
    s0 = stb_cnt; e0 = err_cnt;
    do_write(8'h34, 8'h14, 8'h00, acks);
    total++; if (acks !== 3'b111) begin bad++; $display("FAIL adderr_acks got=%b exp=111", acks); end
    total++; if (err_cnt - e0 !== 1 || stb_cnt != s0) begin bad++;
      $display("FAIL adderr_pulse got err=%0d stb=%0d exp 1/0", err_cnt - e0, stb_cnt - s0); end
    total++; if (REGS_FLAT !== m_flat()) begin bad++;
      $display("FAIL adderr_regs got=%h exp=%h", REGS_FLAT, m_flat()); end
    m_last_addr = 7'h0A;
  endtask

  task automatic test_abort_and_restart();
    logic a0, a1, a2; int s0; logic stb, err;
    s0 = stb_cnt;
    i2c_start(); send_byte(8'h34, a0); send_byte(8'h0E, a1);
    total++; if (BUSY !== 1'b1) begin bad++; $display("FAIL abort_busy_mid got=%b exp=1", BUSY); end
    i2c_stop();
    total++; if (BUSY !== 1'b0 || stb_cnt != s0) begin bad++;
      $display("FAIL abort_stop got busy=%b stb=%0d exp 0/0", BUSY, stb_cnt - s0); end
    i2c_start(); send_byte(8'h34, a0); send_byte(8'h0E, a1);
    i2c_start();
    total++; if (BUSY !== 1'b1 || stb_cnt != s0) begin bad++;
      $display("FAIL rstart_busy got busy=%b stb=%0d exp 1/0", BUSY, stb_cnt - s0); end
    send_byte(8'h34, a0); send_byte(8'h0E, a1); send_byte(8'hAA, a2);
    i2c_stop();
    m_write(7'h07, 9'h0AA, stb, err);
    total++; if ({a0, a1, a2} !== 3'b111 || stb_cnt - s0 !== 1 || mon_data !== 9'h0AA) begin bad++;
      $display("FAIL rstart_commit got acks=%b n=%0d data=%h exp 111/1/0AA", {a0, a1, a2}, stb_cnt - s0, mon_data); end
  endtask

  task automatic test_random();
    logic [2:0] acks; logic [7:0] dv; logic [6:0] a; logic [8:0] d;
    logic estb, eerr; int s0, e0;
    for (int n = 0; n < 16; n++) begin
      dv = ($urandom_range(0, 7) == 0) ? 8'h36 : 8'h34;
      a  = 7'($urandom_range(0, 15));
      d  = 9'($urandom_range(0, 511));
      if (a == 7'h0F && $urandom_range(0, 1) == 1) d = 9'h000;
      s0 = stb_cnt; e0 = err_cnt;
      do_write(dv, {a, d[8]}, d[7:0], acks);
      estb = 1'b0; eerr = 1'b0;
      if (dv == 8'h34) m_write(a, d, estb, eerr);
      total++; if (acks !== ((dv == 8'h34) ? 3'b111 : 3'b000)) begin bad++;
        $display("FAIL rnd_acks n=%0d got=%b dev=%h", n, acks, dv); end
      total++; if ((stb_cnt - s0) != int'(estb) || (err_cnt - e0) != int'(eerr)) begin bad++;
        $display("FAIL rnd_pulses n=%0d got stb=%0d err=%0d exp %0d/%0d", n, stb_cnt - s0, err_cnt - e0, estb, eerr); end
      if (estb) begin
        total++; if (mon_addr !== a || mon_data !== d) begin bad++;
          $display("FAIL rnd_wr n=%0d got %h/%h exp %h/%h", n, mon_addr, mon_data, a, d); end
      end
      total++; if (REGS_FLAT !== m_flat() || ACTIVE !== m_regs[9][0]) begin bad++;
        $display("FAIL rnd_regs n=%0d got=%h exp=%h", n, REGS_FLAT, m_flat()); end
    end
  endtask

  task automatic test_readback();
    logic [2:0] acks; logic a0; logic [7:0] r0, r1; logic stb, err;
    do_write(8'h34, 8'h08, 8'h12, acks);
    m_write(7'h04, 9'h012, stb, err);
`ifdef WM8731_RESP_READBACK_EN
    i2c_start(); send_byte(8'h35, a0);
    recv_byte(1'b1, r0); recv_byte(1'b0, r1);
    i2c_stop();
    total++; if (a0 !== 1'b1) begin bad++; $display("FAIL rb_ack got=%b exp=1", a0); end
    total++; if (r0 !== {m_last_addr, m_regs[4][8]} || r1 !== m_regs[4][7:0]) begin bad++;
      $display("FAIL rb_data got %h %h exp %h %h", r0, r1, {m_last_addr, m_regs[4][8]}, m_regs[4][7:0]); end
`else
    r0 = 8'h00; r1 = 8'h00;
    oe_seen = 1'b0;
    i2c_start(); send_byte(8'h35, a0); i2c_stop();
    total++; if (a0 !== 1'b0 || oe_seen !== 1'b0) begin bad++;
      $display("FAIL rb_nack got ack=%b oe_seen=%b exp 0/0", a0, oe_seen); end
`endif
  endtask

  task automatic test_reset_midtransfer();
    logic [2:0] acks; logic stb, err;
    do_write(8'h34, 8'h0B, 8'hAB, acks);   // R5 = 1AB
    m_write(7'h05, 9'h1AB, stb, err);
    i2c_start();
    for (int i = 7; i >= 0; i--) begin
      sda_m = 1'(8'h34 >> i); #Q; scl_m = 1'b1; #(2*Q); scl_m = 1'b0; #Q;
    end
    sda_m = 1'b1; #Q; scl_m = 1'b1; #Q;
    total++; if (SDA_OE !== 1'b1) begin bad++; $display("FAIL midrst_ack_driven got=%b exp=1", SDA_OE); end
    mon_en = 1'b0;
    RESET = 1'b1; #1;
    m_reset();
    total++; if (SDA_OE !== 1'b0 || BUSY !== 1'b0 || REGS_FLAT !== m_flat()) begin bad++;
      $display("FAIL midrst_state got oe=%b busy=%b regs=%h exp 0/0/%h", SDA_OE, BUSY, REGS_FLAT, m_flat()); end
    repeat (3) @(posedge MCLK);
    #1 RESET = 1'b0;
    #Q; scl_m = 1'b0; #Q;
    i2c_stop();
    mon_en = 1'b1;
  endtask

  initial begin
    test_reset();
    test_write_r7();
    test_active_and_reset_reg();
    test_bad_devaddr();
    test_addr_err();
    test_abort_and_restart();
    test_random();
    test_readback();
    test_reset_midtransfer();
    total++; if (oe_viol != 0) begin bad++; $display("FAIL sda_oe_scl_high got=%0d exp=0", oe_viol); end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
